// File: rtl/vp_pkg.sv
// Shared vector-pipeline definitions: register/element geometry, store FSM
// encoding and element/vector types used by the store unit and its helpers.
package vp_pkg;

    localparam int VEC_W     = 512;
    localparam int ELEM_W    = 32;
    localparam int NUM_ELEM  = VEC_W / ELEM_W;
    localparam int REG_IDX_W = 2;
    localparam int CNT_W     = $clog2(NUM_ELEM);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } vsu_state_t;

    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef logic        [VEC_W-1:0]  vec_t;

endpackage

// File: rtl/vsu_elem_sel.sv
// Combinational NUM_ELEM:1 element selector over a packed vector; element 0
// lives in the least significant ELEM_W bits.
module vsu_elem_sel
    import vp_pkg::*;
(
    input  logic [VEC_W-1:0]  vec,
    input  logic [CNT_W-1:0]  idx,
    output logic [ELEM_W-1:0] elem
);

    always_comb begin
        // NOTE: a default before the loop keeps this purely combinational; without it any unmatched idx would infer a latch.
        elem = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (idx == CNT_W'(i)) begin
                elem = vec[i*ELEM_W +: ELEM_W];
            end
        end
    end

endmodule

// File: rtl/vector_store_unit.sv
// Vector store datapath: snapshots one register-file vector, then streams its
// elements to memory with a valid/ready handshake. Define VSU_STRIDE_EN for a strided address step.
module vector_store_unit
    import vp_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [REG_IDX_W-1:0] reg_sel,
    input  logic [ADDR_W-1:0]    base_addr,
`ifdef VSU_STRIDE_EN
    input  logic [ADDR_W-1:0]    stride,
`endif
    output logic [REG_IDX_W-1:0] rAdd,
    input  logic [VEC_W-1:0]     reg_data,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [ELEM_W-1:0]    mem_wdata,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 done
);

    vsu_state_t          state, state_next;
    logic [VEC_W-1:0]    snapshot;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   step;
    logic [ELEM_W-1:0]   cur_elem;
    logic                accept;
    logic                last_elem;

`ifdef VSU_STRIDE_EN
    logic [ADDR_W-1:0]   stride_q;
    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    assign accept    = mem_we && mem_ready;
    assign last_elem = (cnt == CNT_W'(NUM_ELEM - 1));

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            rAdd     <= '0;
            mem_addr <= '0;
            // NOTE: the snapshot is a plain register bank, not a RAM, so clearing it on reset is cheap and keeps mem_wdata deterministic.
            snapshot <= '0;
            cnt      <= '0;
`ifdef VSU_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        rAdd     <= reg_sel;
                        mem_addr <= base_addr;
`ifdef VSU_STRIDE_EN
                        stride_q <= stride;
`endif
                    end
                end
                READ: begin
                    snapshot <= reg_data;
                    cnt      <= '0;
                end
                SEND: begin
                    if (accept) begin
                        cnt      <= cnt + 1'b1;
                        mem_addr <= mem_addr + step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = READ;
            end
            READ: state_next = SEND;
            SEND: begin
                mem_we = 1'b1;
                if (mem_ready && last_elem) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    vsu_elem_sel u_elem_sel (
        .vec  (snapshot),
        .idx  (cnt),
        .elem (cur_elem)
    );

    // Data bus is quiet outside SEND so idle cycles never show stale elements.
    assign mem_wdata = mem_we ? cur_elem : '0;

endmodule
